// File: rtl/swipt_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : swipt_pkg                                                  |
// | Brief   : Shared state encoding and constants for the SWIPT TX path  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package swipt_pkg;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_PRE   = 3'd1;
  localparam logic [2:0] c_ST_TRANS = 3'd2;
  localparam logic [2:0] c_ST_REC   = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_PRE   = c_ST_PRE,
    ST_TRANS = c_ST_TRANS,
    ST_REC   = c_ST_REC,
    ST_DONE  = c_ST_DONE
  } state_t;

  localparam logic [11:0] L_MAX = 12'h1F4;

  localparam int c_BIT_CYC_DEF = 12288;
  localparam int c_REC_CYC_DEF = 24576;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swipt_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : swipt_bit_timer                                            |
// | Brief   : Down-counter giving bit boundaries and the ack-window end  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module swipt_bit_timer #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] reload_val,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (load || tick) begin
      r_cnt <= reload_val;
    end else if (enable) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/swipt_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : swipt_tx_sequencer                                         |
// | Brief   : SWIPT downlink frame sequencer (preamble, payload, ack).   |
// |           Define SWIPT_TX_PARITY_EN to append an even-parity bit.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module swipt_tx_sequencer
  import swipt_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int BIT_CYC  = c_BIT_CYC_DEF,
  parameter int PRE_BITS = 4,
  parameter int REC_CYC  = c_REC_CYC_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              rx_ack,
  output logic              startup_data,
  output logic              data_start,
  output logic              data_trans,
  output logic              data_rec,
  output logic              d,
  output logic              busy,
  output logic              done,
  output logic              ack_ok
);

`ifdef SWIPT_TX_PARITY_EN
  localparam int c_TX_BITS = DATA_W + 1;
`else
  localparam int c_TX_BITS = DATA_W;
`endif
  localparam int c_CNT_W = $clog2(max_int(PRE_BITS, DATA_W) + 1);
  localparam int c_TMR_W = $clog2(max_int(BIT_CYC, REC_CYC));

  localparam logic [c_CNT_W-1:0] c_PRE_LAST   = c_CNT_W'(PRE_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_TX_LAST    = c_CNT_W'(c_TX_BITS - 1);
  localparam logic [c_TMR_W-1:0] c_BIT_RELOAD = c_TMR_W'(BIT_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_REC_RELOAD = c_TMR_W'(REC_CYC - 1);

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_bit_cnt;
  logic [c_TX_BITS-1:0]   r_shreg;
  logic                   r_tx_ready;
  logic                   r_startup_data;
  logic                   r_data_start;
  logic                   r_data_trans;
  logic                   r_data_rec;
  logic                   r_d;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ack_ok;

  logic                   w_accept;
  logic                   w_tick;
  logic                   w_tmr_en;
  logic                   w_last_tx;
  logic [c_TMR_W-1:0]     w_reload;
  logic [c_TX_BITS-1:0]   w_load_word;

`ifdef SWIPT_TX_PARITY_EN
  assign w_load_word = {tx_data, ^tx_data};
`else
  assign w_load_word = tx_data;
`endif

  assign w_accept  = tx_valid && r_tx_ready;
  assign w_tmr_en  = (r_state == ST_PRE) || (r_state == ST_TRANS) || (r_state == ST_REC);
  assign w_last_tx = (r_state == ST_TRANS) && (r_bit_cnt == c_TX_LAST);
  // The final payload boundary reloads the timer with the ack-window length.
  assign w_reload  = w_last_tx ? c_REC_RELOAD : c_BIT_RELOAD;

  swipt_bit_timer #(
    .CNT_W (c_TMR_W)
  ) u_bit_timer (
    .clk        (clk),
    .nrst       (nrst),
    .load       (w_accept),
    .enable     (w_tmr_en),
    .reload_val (w_reload),
    .tick       (w_tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      r_tx_ready     <= 1'b0;
      r_startup_data <= 1'b0;
      r_data_start   <= 1'b0;
      r_data_trans   <= 1'b0;
      r_data_rec     <= 1'b0;
      r_d            <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_ack_ok       <= 1'b0;
    end else if (!en) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_tx_ready     <= 1'b0;
      r_startup_data <= 1'b0;
      r_data_start   <= 1'b0;
      r_data_trans   <= 1'b0;
      r_data_rec     <= 1'b0;
      r_d            <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_ack_ok <= 1'b0;
      end
    end else begin
      // Outputs trail the state by one cycle.
      r_startup_data <= (r_state == ST_PRE);
      r_data_start   <= w_tmr_en;
      r_data_trans   <= (r_state == ST_TRANS);
      r_data_rec     <= (r_state == ST_REC);
      r_busy         <= w_tmr_en;
      r_done         <= (r_state == ST_DONE);
      r_tx_ready     <= 1'b0;
      case (r_state)
        ST_PRE:   r_d <= ~r_bit_cnt[0];
        ST_TRANS: r_d <= r_shreg[c_TX_BITS-1];
        default:  r_d <= 1'b0;
      endcase

      case (r_state)
        ST_IDLE: begin
          r_tx_ready <= !w_accept;
          if (w_accept) begin
            r_shreg   <= w_load_word;
            r_ack_ok  <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (w_tick) begin
            if (r_bit_cnt == c_PRE_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= ST_TRANS;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_TRANS: begin
          if (w_tick) begin
            r_shreg <= r_shreg << 1;
            if (w_last_tx) begin
              r_bit_cnt <= '0;
              r_state   <= ST_REC;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
          end
        end
        ST_REC: begin
          if (rx_ack) begin
            r_ack_ok <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_tick) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready     = r_tx_ready;
  assign startup_data = r_startup_data;
  assign data_start   = r_data_start;
  assign data_trans   = r_data_trans;
  assign data_rec     = r_data_rec;
  assign d            = r_d;
  assign busy         = r_busy;
  assign done         = r_done;
  assign ack_ok       = r_ack_ok;

endmodule
`default_nettype wire
